// File: rtl/keypad_pkg.sv
// Shared widths, enums and the frame classifier for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } frame_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_RELEASE_CHK
  } deb_state_e;

  typedef struct packed {
    frame_class_e            cls;
    logic [CODE_W-1:0]       code;
  } frame_result_t;

  // Bit index r*COLS+c of hits doubles as the key code {row, col}.
  function automatic frame_result_t classify(input logic [ROWS*COLS-1:0] hits);
    frame_result_t res;
    int unsigned   n;
    n        = 0;
    res.code = '0;
    for (int unsigned i = 0; i < ROWS*COLS; i++) begin
      if (hits[i]) begin
        n        = n + 1;
        res.code = CODE_W'(i);
      end
    end
    if (n == 0)      res.cls = CLS_NONE;
    else if (n == 1) res.cls = CLS_SINGLE;
    else             res.cls = CLS_MULTI;
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle between the scanner and its surroundings.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [COLS-1:0]   col_n;
  logic [ROWS-1:0]   row_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_down;

  modport master (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_down
  );

  modport slave (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchronizer with a caller-supplied reset value.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix scanner: walks one active-low row at a time, classifies each
// full frame and debounces presses/releases over whole frames.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS      = 8,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kif
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned CNT_W  = 4;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0]  DEB_N     = CNT_W'(DEBOUNCE_FRAMES);

  logic [COLS-1:0]        col_sync;
  logic [COLS-1:0]        col_hit;

  logic                   scan_en_q,   scan_en_d;
  logic [TICK_W-1:0]      tick_q,      tick_d;
  logic [1:0]             row_q,       row_d;
  logic [ROWS-1:0]        row_n_q,     row_n_d;
  logic [(ROWS-1)*COLS-1:0] hits_acc_q, hits_acc_d;
  deb_state_e             state_q,     state_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CODE_W-1:0]      cand_q,      cand_d;
  logic [CODE_W-1:0]      key_code_q,  key_code_d;
  logic                   key_valid_q, key_valid_d;
  logic                   key_down_q,  key_down_d;

  logic                   sample;
  logic                   frame_done;
  frame_result_t          res;

  sync_2ff #(.WIDTH(COLS)) u_col_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rst_val ({COLS{1'b1}}),
    .d       (kif.col_n),
    .q       (col_sync)
  );

  assign col_hit    = ~col_sync;
  assign sample     = scan_en_q && (tick_q == TICK_LAST);
  assign frame_done = sample && (row_q == 2'd3);
  assign cnt_inc    = cnt_q + CNT_W'(1);
  // Row 3 is judged straight from the synchronizer so the decision lands one cycle after its sample.
  assign res        = classify({col_hit, hits_acc_q});

  always_comb begin
    scan_en_d   = scan_en_q;
    tick_d      = tick_q;
    row_d       = row_q;
    row_n_d     = row_n_q;
    hits_acc_d  = hits_acc_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    // Row walker: first cycle out of reset drives row 0, then SCAN_TICKS per row.
    if (!scan_en_q) begin
      scan_en_d = 1'b1;
      tick_d    = '0;
      row_d     = 2'd0;
      row_n_d   = ~ROWS'(1);
    end else if (tick_q == TICK_LAST) begin
      tick_d  = '0;
      row_d   = row_q + 2'd1;
      row_n_d = ~(ROWS'(1) << row_d);
    end else begin
      tick_d = tick_q + TICK_W'(1);
    end

    if (sample) begin
      case (row_q)
        2'd0:    hits_acc_d[3:0]  = col_hit;
        2'd1:    hits_acc_d[7:4]  = col_hit;
        2'd2:    hits_acc_d[11:8] = col_hit;
        default: ;
      endcase
    end

    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (res.cls == CLS_SINGLE) begin
            cand_d = res.code;
            cnt_d  = CNT_W'(1);
            if (DEB_N == CNT_W'(1)) begin
              key_code_d  = res.code;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = ST_HELD;
            end else begin
              state_d = ST_PRESS_CHK;
            end
          end
        end
        ST_PRESS_CHK: begin
          if (res.cls != CLS_SINGLE) begin
            state_d = ST_IDLE;
          end else if (res.code != cand_q) begin
            cand_d = res.code;
            cnt_d  = CNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              state_d     = ST_HELD;
            end
          end
        end
        ST_HELD: begin
          // A different lone key means the held one is gone.
          if (res.cls == CLS_NONE ||
              (res.cls == CLS_SINGLE && res.code != key_code_q)) begin
            cnt_d = CNT_W'(1);
            if (DEB_N == CNT_W'(1)) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_RELEASE_CHK;
            end
          end
        end
        ST_RELEASE_CHK: begin
          if (res.cls == CLS_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              key_down_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en_q   <= 1'b0;
      tick_q      <= '0;
      row_q       <= 2'd0;
      row_n_q     <= '1;
      hits_acc_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      scan_en_q   <= scan_en_d;
      tick_q      <= tick_d;
      row_q       <= row_d;
      row_n_q     <= row_n_d;
      hits_acc_q  <= hits_acc_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign kif.row_n     = row_n_q;
  assign kif.key_code  = key_code_q;
  assign kif.key_valid = key_valid_q;
  assign kif.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives col_n from row_n,
// a step table sets keys per frame and states the events expected in each window.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          errors;
  int          pulses;
  logic        prev_valid;
  logic        prev_down;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_TICKS      (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed key (r,c) pulls column c low while row r is driven low.
  always_comb begin
    kif.col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.row_n[r]) kif.col_n[c] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic        down;
  } step_t;

  step_t steps[$];

  function automatic logic [15:0] k(input int r, input int c);
    return 16'(1) << (r*4 + c);
  endfunction

  task automatic add(input logic [15:0] kv, input int fr, input int np,
                     input logic [3:0] code, input logic down);
    step_t s;
    s.keys = kv; s.frames = fr; s.pulses = np; s.code = code; s.down = down;
    steps.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: step to the falling edge, check the row walk and event alignment.
  task automatic tick();
    logic [3:0] exp_row;
    @(negedge clk);
    if (rst_n && cyc > 0) begin
      exp_row = 4'b0001;
      exp_row = ~(exp_row << (((cyc - 1) / 4) % 4));
      check("row_n", 32'(kif.row_n), 32'(exp_row));
    end
    if (kif.key_valid) begin
      pulses++;
      check("valid_width", 32'(prev_valid), 32'(0));
      check("valid_align", 32'(cyc % 16), 32'(1));
    end
    if (rst_n && kif.key_down !== prev_down)
      check("down_align", 32'(cyc % 16), 32'(1));
    prev_valid = kif.key_valid;
    prev_down  = kif.key_down;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row_n"},     32'(kif.row_n),     32'hF);
    check({tag, "_key_code"},  32'(kif.key_code),  32'h0);
    check({tag, "_key_valid"}, 32'(kif.key_valid), 32'h0);
    check({tag, "_key_down"},  32'(kif.key_down),  32'h0);
  endtask

  initial begin
    logic found;
    checks = 0; errors = 0; pulses = 0;
    prev_valid = 1'b0; prev_down = 1'b0;
    keys  = 16'h0;
    rst_n = 1'b0;

    // Clean press / hold / interrupted release of (2,1)
    add(16'h0,      2, 0, 4'h0, 1'b0);
    add(k(2,1),     2, 0, 4'h0, 1'b0);
    add(k(2,1),     1, 1, 4'h9, 1'b1);
    add(k(2,1),     3, 0, 4'h9, 1'b1);
    add(16'h0,      2, 0, 4'h9, 1'b1);
    add(k(2,1),     1, 0, 4'h9, 1'b1);
    add(16'h0,      2, 0, 4'h9, 1'b1);
    add(16'h0,      1, 0, 4'h9, 1'b0);
    add(16'h0,      1, 0, 4'h9, 1'b0);
    // Bouncing (0,3), then held
    for (int i = 0; i < 8; i++)
      add((i % 2 == 0) ? k(0,3) : 16'h0, 1, 0, 4'h9, 1'b0);
    add(k(0,3),     2, 0, 4'h9, 1'b0);
    add(k(0,3),     1, 1, 4'h3, 1'b1);
    add(16'h0,      3, 0, 4'h3, 1'b0);
    // Chord from idle, then a second key added while held
    add(k(1,1) | k(3,2), 4, 0, 4'h3, 1'b0);
    add(k(1,1),     2, 0, 4'h3, 1'b0);
    add(k(1,1),     1, 1, 4'h5, 1'b1);
    add(k(1,1) | k(0,0), 2, 0, 4'h5, 1'b1);
    add(16'h0,      3, 0, 4'h5, 1'b0);
    // Candidate change during the press check
    add(k(1,0),     2, 0, 4'h5, 1'b0);
    add(k(1,2),     2, 0, 4'h5, 1'b0);
    add(k(1,2),     1, 1, 4'h6, 1'b1);
    add(16'h0,      3, 0, 4'h6, 1'b0);
    add(k(2,1),     3, 1, 4'h9, 1'b1);

    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < steps.size(); i++) begin
      keys   = steps[i].keys;
      pulses = 0;
      repeat (steps[i].frames * 16) tick();
      check($sformatf("step%0d_pulses", i),   32'(pulses),       32'(steps[i].pulses));
      check($sformatf("step%0d_key_code", i), 32'(kif.key_code), 32'(steps[i].code));
      check($sformatf("step%0d_key_down", i), 32'(kif.key_down), 32'(steps[i].down));
    end

    // Asynchronous reset in the middle of a frame with (2,1) held
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) tick();
    check_reset_vals("midrst_hold");
    rst_n = 1'b1;
    tick();
    check("restart_row_n", 32'(kif.row_n), 32'hE);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      tick();
      if (kif.key_valid) found = 1'b1;
    end
    check("restart_press_seen", 32'(found), 32'(1));
    if (found) begin
      check("restart_press_cycle", 32'(cyc), 32'(49));
      check("restart_press_code",  32'(kif.key_code), 32'h9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 mechanical key matrix by driving one row low at a time and sampling the column lines.
- Debounces the scan result across whole frames and reports a single accepted keypress as a 4-bit code with a one-cycle valid strobe, plus a held key-down level.
- Sits between the board keypad pins and the front-panel control logic.
- Complements the single-key edge detector: this block drives the key interface and produces the events itself.

Parameters:
- SCAN_TICKS, 8: clk cycles each row is held active. Must be >= 4.
- DEBOUNCE_FRAMES, 4: number of consecutive identical full-matrix frames required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- col_n  input  4  matrix column lines, active-low (externally pulled up), asynchronous to clk
- row_n  output  4  matrix row drive, active-low, at most one bit low at any time
- key_code  output  4  accepted key, {row[1:0], col[1:0]}
- key_valid  output  1  one-cycle pulse when a new press is accepted
- key_down  output  1  high while an accepted key is held

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values: row_n=4'b1111, key_code=0, key_valid=0, key_down=0. All counters and the synchronizer are cleared to 0 / all-ones-idle as appropriate.
- Synchronizer: col_n passes through a 2-flop synchronizer, reset to 4'b1111.
- Row sequence: on the first cycle after reset release, row_n=4'b1110 (row 0).
  - Each row is held for exactly SCAN_TICKS cycles.
  - Rows advance 0->1->2->3->0 with no idle gap.
  - row_n is registered, so the output is glitch-free.
- Sampling: the synchronized columns are captured on the last cycle of each row's slot. The first SCAN_TICKS-1 cycles cover line settling and synchronizer latency.
- Frame evaluation: a frame is one pass over rows 0..3. After the row-3 sample, the frame is classified as:
  - NONE: no column low in any row.
  - SINGLE(code): exactly one (row,col) low across the whole frame.
  - MULTI: two or more low, which covers ghosting and chords.
- Debounce state machine (states IDLE, PRESS_CHK, HELD, RELEASE_CHK); the counter cnt counts frames:
  - IDLE:
    - SINGLE(c): latch cand=c, cnt=1, go to PRESS_CHK. If DEBOUNCE_FRAMES==1, accept immediately.
    - NONE or MULTI: stay.
  - PRESS_CHK:
    - SINGLE(cand): cnt++.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
    - When cnt reaches DEBOUNCE_FRAMES: key_code<=cand, key_valid pulses, key_down<=1, go to HELD.
  - HELD:
    - NONE: cnt=1, go to RELEASE_CHK.
    - SINGLE(key_code) or MULTI: stay. A second key added while holding produces no new event.
    - SINGLE(other): treat as NONE for the held key and start release.
  - RELEASE_CHK:
    - NONE: cnt++.
    - Anything else: go back to HELD.
    - When cnt reaches DEBOUNCE_FRAMES: key_down<=0, go to IDLE. key_code keeps its last value.
- Latency: key_valid and the key_down rise/fall occur exactly 1 cycle after the last sample cycle of the deciding frame.
- key_valid width: exactly 1 cycle, at most once per frame.
- Reset mid-frame: everything returns to reset values immediately, and scanning restarts at row 0 after release.
- Rollover: the row and tick counters wrap without loss. A frame is exactly 4*SCAN_TICKS cycles.

Decomposition:
- Package keypad_pkg: ROWS=4, COLS=4, CODE_W=4, the frame-class enum (NONE/SINGLE/MULTI) and the debounce state enum.
- One sub-module, sync_2ff (width-parameterised 2-flop synchronizer with reset value input), used for col_n.
- Scan counter, frame classifier and debounce FSM stay in keypad_scanner.

Test Plan (SCAN_TICKS=4, DEBOUNCE_FRAMES=3, frame=16 cycles; the bench model pulls col_n[c] low whenever row_n[r]==0 and key (r,c) is closed):
- Reset/scan: release rst_n, no keys -> row_n walks 1110,1101,1011,0111 with 4 cycles each, repeating. key_valid never asserts. Outputs hold reset values during and after an asynchronous mid-frame reset.
- Clean press: close key (2,1) for 6 frames -> key_valid pulses once, with key_code=4'h9 and key_down=1, 1 cycle after the end of the 3rd full frame containing the key.
- Bounce: toggle key (0,3) open/closed every frame for 8 frames, then hold it closed -> no key_valid until 3 consecutive closed frames. Then exactly one pulse with key_code=4'h3.
- Release: after the clean press, open the key -> key_down falls 1 cycle after the 3rd consecutive empty frame. key_code stays 4'h9. A release interrupted by one closed frame restarts the count.
- Multi-key: hold keys (1,1) and (3,2) together from IDLE -> no key_valid, key_down stays 0. Release (3,2) -> key_valid after 3 frames with key_code=4'h5.
- Change during check: (1,0) for 2 frames, then (1,2) for 3 frames -> a single key_valid with key_code=4'h6. No event for 4'h4.
